// File: rtl/memory_responder.sv
// Wait-state memory responder: latches a Read/Write request, inserts WAIT_CYCLES wait states, then strobes Done.
// Optional macro MEM_RANGE_CHECK_EN adds the Error port and out-of-range access suppression.
module memory_responder #(
    parameter int unsigned ADDR_BITS   = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] Mdatain,
    output logic        Done
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic        Error
`endif
);

    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE,
        HOLD
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [3:0]           wait_cnt;
    logic [3:0]           wait_cnt_next;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          data_q;
    logic                 op_read;
    logic                 op_write;
    logic                 take;
    logic                 mem_we;
    logic                 rd_en;
    logic                 blocked;

    // Zero at elaboration; deliberately untouched by clear.
    logic [31:0] mem [DEPTH] = '{default: '0};

`ifdef MEM_RANGE_CHECK_EN
    logic range_err;
    assign blocked = range_err;
    assign Error   = Done && range_err;
`else
    assign blocked = 1'b0;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        take          = 1'b0;
        mem_we        = 1'b0;
        rd_en         = 1'b0;
        Done          = 1'b0;
        case (state)
            IDLE: begin
                if (Read || Write) begin
                    take       = 1'b1;
                    state_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = ACCESS;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            ACCESS: begin
                mem_we     = op_write && !blocked;
                rd_en      = op_read && !blocked;
                state_next = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                // A request still held after Done must not be re-executed.
                if (!Read && !Write) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            addr_q    <= '0;
            data_q    <= '0;
            op_read   <= 1'b0;
            op_write  <= 1'b0;
            Mdatain   <= '0;
`ifdef MEM_RANGE_CHECK_EN
            range_err <= 1'b0;
`endif
        end else begin
            if (take) begin
                addr_q    <= address[ADDR_BITS-1:0];
                data_q    <= write_data;
                op_read   <= Read;
                // Read wins a simultaneous request.
                op_write  <= Write && !Read;
`ifdef MEM_RANGE_CHECK_EN
                range_err <= |address[31:ADDR_BITS];
`endif
            end
            if (rd_en) begin
                Mdatain <= mem[addr_q];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: vector table, hand sequences and random traffic vs a reference model.
module tb_memory_responder;

    localparam int unsigned W     = 2;
    localparam int unsigned DEPTH = 512;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] address, write_data;
    logic        Read, Write;
    logic [31:0] Mdatain;
    logic        Done;
    logic        err;

    logic [31:0] a0, d0;
    logic        r0, w0;
    logic [31:0] m0;
    logic        done0;
    logic        err0;

    always #5 clock = ~clock;

    memory_responder #(.ADDR_BITS(9), .WAIT_CYCLES(W)) dut (
        .clock(clock), .clear(clear), .address(address), .write_data(write_data),
        .Read(Read), .Write(Write), .Mdatain(Mdatain), .Done(Done)
`ifdef MEM_RANGE_CHECK_EN
        , .Error(err)
`endif
    );

    memory_responder #(.ADDR_BITS(9), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .clear(clear), .address(a0), .write_data(d0),
        .Read(r0), .Write(w0), .Mdatain(m0), .Done(done0)
`ifdef MEM_RANGE_CHECK_EN
        , .Error(err0)
`endif
    );

`ifndef MEM_RANGE_CHECK_EN
    assign err  = 1'b0;
    assign err0 = 1'b0;
`endif

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_mdat;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_mdat;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic void model_apply(input logic rd, input logic wr, input logic [31:0] a,
                                        input logic [31:0] d, output logic [31:0] exp_m,
                                        output logic exp_e);
        int unsigned idx = a % DEPTH;
        logic oor = (a / DEPTH) != 0;
        exp_e = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        if (oor) exp_e = 1'b1;
`else
        oor = 1'b0;
`endif
        if (!oor) begin
            if (rd) ref_mdat = ref_mem[idx];
            else if (wr) ref_mem[idx] = d;
        end
        exp_m = ref_mdat;
    endfunction

    // One complete request on the W-wait instance; Done expected after edge W+1 following sampling.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_m, input logic exp_e, input string name);
        @(negedge clock);
        Read = rd; Write = wr; address = a; write_data = d;
        @(posedge clock);
        #1;
        address = $urandom; write_data = $urandom;
        for (int i = 1; i <= int'(W) + 3; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s done@%0d", name, i), 32'(Done), 32'(i == int'(W) + 1));
`ifdef MEM_RANGE_CHECK_EN
            check($sformatf("%s error@%0d", name, i), 32'(err), 32'((i == int'(W) + 1) && exp_e));
`endif
            if (i == int'(W) + 1) begin
                check($sformatf("%s mdatain", name), Mdatain, exp_m);
                Read = 1'b0; Write = 1'b0;
            end
        end
    endtask

    task automatic vec(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_m, input logic exp_e, input string name);
        logic [31:0] m;
        logic e;
        model_apply(rd, wr, a, d, m, e);
        access(rd, wr, a, d, exp_m, exp_e, name);
    endtask

    task automatic access0(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_m, input string name);
        @(negedge clock);
        r0 = rd; w0 = wr; a0 = a; d0 = d;
        @(posedge clock);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s done0@%0d", name, i), 32'(done0), 32'(i == 1));
            if (i == 1) begin
                check($sformatf("%s m0", name), m0, exp_m);
                r0 = 1'b0; w0 = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] em;
        logic        ee;
        int unsigned pulses;
        logic [31:0] ra, rd_v;
        logic        rr, rw;
        int unsigned op;

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        ref_mdat = '0;

        tbl[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b0, 1'b1, 32'h05, 32'h11,       32'hDEADBEEF};
        tbl[3] = '{1'b1, 1'b1, 32'h05, 32'hFFFFFFFF, 32'h11};
        tbl[4] = '{1'b1, 1'b0, 32'h05, 32'h0,        32'h11};
        tbl[5] = '{1'b1, 1'b0, 32'h1F0, 32'h0,       32'h0};
        tbl[6] = '{1'b0, 1'b1, 32'h03, 32'hA5A5A5A5, 32'h0};

        clear = 1'b0;
        Read = 1'b0; Write = 1'b0; address = '0; write_data = '0;
        r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset done", 32'(Done), 32'h0);
        check("reset mdatain", Mdatain, 32'h0);
        check("reset error", 32'(err), 32'h0);
        @(negedge clock);
        clear = 1'b1;

        foreach (tbl[i])
            vec(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_mdat, 1'b0,
                $sformatf("tbl%0d", i));

        // Read held for 10 cycles after Done: exactly one pulse, then a fresh request is accepted.
        @(negedge clock);
        Read = 1'b1; address = 32'h10;
        @(posedge clock);
        pulses = 0;
        for (int i = 1; i <= int'(W) + 11; i++) begin
            @(posedge clock);
            #1;
            if (Done) pulses++;
        end
        check("hold pulses", 32'(pulses), 32'd1);
        check("hold mdatain", Mdatain, 32'hDEADBEEF);
        model_apply(1'b1, 1'b0, 32'h10, 32'h0, em, ee);
        @(negedge clock);
        Read = 1'b0;
        vec(1'b1, 1'b0, 32'h03, 32'h0, 32'hA5A5A5A5, 1'b0, "after_hold");

        // Out-of-range write: suppressed with Error when checking is built in, wraps otherwise.
`ifdef MEM_RANGE_CHECK_EN
        vec(1'b0, 1'b1, 32'h205, 32'h99, 32'hA5A5A5A5, 1'b1, "range_wr");
        vec(1'b1, 1'b0, 32'h005, 32'h0, 32'h11, 1'b0, "range_rd");
`else
        vec(1'b0, 1'b1, 32'h205, 32'h99, 32'hA5A5A5A5, 1'b0, "range_wr");
        vec(1'b1, 1'b0, 32'h005, 32'h0, 32'h99, 1'b0, "range_rd");
`endif

        // Reset in WAIT aborts the write with no Done.
        vec(1'b0, 1'b1, 32'h20, 32'hCAFE0020, 32'h11 ^ 32'h11 ^ ref_mdat, 1'b0, "pre_rst");
        @(negedge clock);
        Write = 1'b1; address = 32'h20; write_data = 32'h12345678;
        @(posedge clock);
        #3;
        clear = 1'b0;
        Write = 1'b0;
        #1;
        check("abort done", 32'(Done), 32'h0);
        check("abort mdatain", Mdatain, 32'h0);
        ref_mdat = '0;
        pulses = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (Done) pulses++;
        end
        @(negedge clock);
        clear = 1'b1;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (Done) pulses++;
        end
        check("abort pulses", 32'(pulses), 32'd0);
        vec(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFE0020, 1'b0, "post_rst");

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            rr = (op != 1);
            rw = (op != 0);
            ra = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ra = ra | (32'($urandom_range(1, 255)) << 9);
            rd_v = $urandom;
            model_apply(rr, rw, ra, rd_v, em, ee);
            access(rr, rw, ra, rd_v, em, ee, $sformatf("rnd%0d", n));
        end

        access0(1'b0, 1'b1, 32'h1F1, 32'h5555AAAA, 32'h0, "z_wr");
        access0(1'b1, 1'b0, 32'h1F1, 32'h0, 32'h5555AAAA, "z_rd");
        access0(1'b1, 1'b0, 32'h1F0, 32'h0, 32'h0, "z_unwritten");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 9, giving the word-address width (memory depth 2^ADDR_BITS words of 32 bits).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait states (0..15) inserted before each access.
REQ-003 Port clock, input, 1: single system clock; all state changes on its rising edge.
REQ-004 Port clear, input, 1: reset, asynchronous, active-low.
REQ-005 Port address, input, 32: word address driven from MAR.
REQ-006 Port write_data, input, 32: store data driven from MDR.
REQ-007 Port Read, input, 1: read request level, held by the requester until Done is seen.
REQ-008 Port Write, input, 1: write request level, held by the requester until Done is seen.
REQ-009 Port Mdatain, output, 32: read data returned toward the MDR.
REQ-010 Port Done, output, 1: access-complete strobe.
REQ-011 Port Error, output, 1: address-range error strobe; present only when MEM_RANGE_CHECK_EN is defined.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, ACCESS, DONE, and HOLD.
REQ-013 In IDLE, a rising edge with Read or Write high SHALL latch address[ADDR_BITS-1:0], write_data and the operation type.
- Next state: WAIT if WAIT_CYCLES > 0, else ACCESS.
REQ-014 WAIT SHALL count WAIT_CYCLES clock cycles with a 4-bit counter, then go to ACCESS.
REQ-015 ACCESS SHALL last one cycle, then go to DONE.
- Read: memory[latched address] is copied to Mdatain.
- Write: latched write_data is stored to memory[latched address].
REQ-016 Done SHALL be high for exactly the one cycle spent in DONE.
- Done is therefore high in cycle k+WAIT_CYCLES+2, where k is the request-sampling edge.
REQ-017 DONE SHALL always go to HOLD.
REQ-018 HOLD SHALL remain until Read and Write are both low, then go to IDLE.
- A request still held after Done is not re-executed.
REQ-019 Changes on address, write_data, Read or Write after the sampling edge SHALL NOT affect the access in progress.
REQ-020 If Read and Write are both high at the sampling edge, the access SHALL be a read, and no memory location is written.
REQ-021 Mdatain SHALL hold its last read value through writes and idle periods; it changes only in ACCESS of a read.
REQ-022 A read of a never-written location SHALL return 0.
- Memory is zero-initialised at elaboration.
REQ-023 Address bits above ADDR_BITS-1 SHALL be ignored (addresses wrap modulo 2^ADDR_BITS) unless MEM_RANGE_CHECK_EN is defined.

Reset
REQ-024 While clear is low, the FSM SHALL be in IDLE, with Done=0, Mdatain=0, Error=0, and the wait counter at 0.
REQ-025 Asserting clear mid-operation SHALL abort the access with no memory write and no Done pulse.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 The first request SHALL be sampled on the first rising edge after clear goes high.

Configuration
REQ-028 Macro MEM_RANGE_CHECK_EN SHALL control address-range checking.
- Defined: if any of address[31:ADDR_BITS] is nonzero at the sampling edge, the access completes with normal Done timing but performs no memory write and leaves Mdatain unchanged; Error pulses high in the same cycle as Done.
- Undefined: the Error port and all checking logic are absent, and out-of-range addresses wrap per REQ-023.

Verification
REQ-029 Write test: WAIT_CYCLES=2, Write with address=0x10, write_data=0xDEADBEEF -> Done high exactly 4 cycles after the sampling edge; a subsequent Read of 0x10 returns Mdatain=0xDEADBEEF.
REQ-030 Zero-wait test: WAIT_CYCLES=0, Read of an unwritten address 0x1F0 -> Done 2 cycles after sampling; Mdatain=0x00000000.
REQ-031 Hold test: Read held high for 10 cycles after Done -> exactly one Done pulse; FSM stays in HOLD until Read drops, then accepts a new request.
REQ-032 Reset test: clear driven low during WAIT of a write to 0x20 with data 0x12345678 -> no Done; a later Read of 0x20 returns its prior contents.
REQ-033 Conflict test: Read and Write both high, address=0x05, write_data=0xFFFFFFFF, location holds 0x11 -> Mdatain=0x00000011; location still 0x11.
REQ-034 Range test: with MEM_RANGE_CHECK_EN defined, Write to 0x00000205 -> Error and Done in the same cycle; location 0x005 is unchanged.
- With the macro undefined, the same write updates location 0x005.
